// File: rtl/mult_issue_ctrl.sv
// Operand issue and result collection around the fixed-latency multiplier core.
// Optional MULT_ISSUE_STATS_EN adds saturating accept/stall counters.
module mult_issue_ctrl #(
  parameter int WIDTH       = 32,
  parameter int MUL_LATENCY = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] mul_a,
  output logic [WIDTH-1:0] mul_b,
  input  logic [WIDTH-1:0] mul_z,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_z,
  output logic             busy
`ifdef MULT_ISSUE_STATS_EN
  ,
  output logic [15:0]      stat_issued,
  output logic [15:0]      stat_stall
`endif
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + MUL_LATENCY + 1);

  logic [MUL_LATENCY-1:0]               vld_pipe_q, vld_pipe_d;
  logic [WIDTH-1:0]                     mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [FIFO_DEPTH-1:0][WIDTH-1:0]     mem_q, mem_d;
  logic [PW-1:0]                        rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                        cnt_q, cnt_d;
  logic [CW-1:0]                        inflight;
  logic                                 accept, push, pop;

  // Credits are derived from registered state only, so a pop frees a slot one cycle later.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < MUL_LATENCY; i++) inflight = inflight + CW'(vld_pipe_q[i]);
  end

  assign in_ready  = !rst && !flush && ((inflight + cnt_q) < CW'(FIFO_DEPTH));
  assign accept    = in_valid && in_ready;
  assign push      = vld_pipe_q[MUL_LATENCY-1] && !flush;
  assign pop       = out_ready && (cnt_q != '0) && !flush;

  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    vld_pipe_d = '0;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    cnt_d      = cnt_q;

    if (accept) begin
      mul_a_d = in_a;
      mul_b_d = in_b;
    end
    vld_pipe_d[0] = accept;
    for (int i = 1; i < MUL_LATENCY; i++) vld_pipe_d[i] = vld_pipe_q[i-1];

    if (push) begin
      mem_d[wr_ptr_q] = mul_z;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase

    // Flush drops everything in flight and queued; operand registers keep their value.
    if (flush) begin
      vld_pipe_d = '0;
      cnt_d      = '0;
      rd_ptr_d   = wr_ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe_q <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mem_q      <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      cnt_q      <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mem_q      <= mem_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      cnt_q      <= cnt_d;
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign out_valid = (cnt_q != '0);
  assign out_z     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign busy      = (|vld_pipe_q) || out_valid;

`ifdef MULT_ISSUE_STATS_EN
  logic [15:0] issued_q, issued_d, stall_q, stall_d;

  always_comb begin
    issued_d = issued_q;
    stall_d  = stall_q;
    if (accept && (issued_q != 16'hFFFF)) issued_d = issued_q + 16'd1;
    if (in_valid && !in_ready && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_d;
      stall_q  <= stall_d;
    end
  end

  assign stat_issued = issued_q;
  assign stat_stall  = stall_q;
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Directed bench for mult_issue_ctrl: default instance plus an 8-deep FIFO instance
// used for the sustained push/pop case. Each core is modelled as one register stage.
module tb_mult_issue_ctrl;

  logic        clk, rst;
  logic        flush, in_valid, out_ready;
  logic [31:0] in_a, in_b;
  logic        in_ready, out_valid, busy;
  logic [31:0] mul_a, mul_b, mul_z, out_z;

  logic        u2_flush, u2_in_valid, u2_out_ready;
  logic [31:0] u2_in_a, u2_in_b;
  logic        u2_in_ready, u2_out_valid, u2_busy;
  logic [31:0] u2_mul_a, u2_mul_b, u2_mul_z, u2_out_z;

`ifdef MULT_ISSUE_STATS_EN
  logic [15:0] s_iss, s_stl, u2_s_iss, u2_s_stl;
`endif

  int passes = 0;
  int total  = 0;
  int acc;

  mult_issue_ctrl dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mul_a(mul_a), .mul_b(mul_b), .mul_z(mul_z),
    .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z), .busy(busy)
`ifdef MULT_ISSUE_STATS_EN
    , .stat_issued(s_iss), .stat_stall(s_stl)
`endif
  );

  mult_issue_ctrl #(.FIFO_DEPTH(8)) dut2 (
    .clk(clk), .rst(rst), .flush(u2_flush), .in_valid(u2_in_valid), .in_ready(u2_in_ready),
    .in_a(u2_in_a), .in_b(u2_in_b), .mul_a(u2_mul_a), .mul_b(u2_mul_b), .mul_z(u2_mul_z),
    .out_valid(u2_out_valid), .out_ready(u2_out_ready), .out_z(u2_out_z), .busy(u2_busy)
`ifdef MULT_ISSUE_STATS_EN
    , .stat_issued(u2_s_iss), .stat_stall(u2_s_stl)
`endif
  );

  // Latency-2 core: product visible one cycle after the operand registers update.
  always @(posedge clk) begin
    mul_z    <= mul_a * mul_b;
    u2_mul_z <= u2_mul_a * u2_mul_b;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_a = '0; in_b = '0;
    u2_flush = 1'b0; u2_in_valid = 1'b0; u2_out_ready = 1'b0; u2_in_a = '0; u2_in_b = '0;
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_out_z", out_z, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", in_ready, 1);

    // Single op 3*5
    in_valid = 1'b1; in_a = 3; in_b = 5;
    tick();
    in_valid = 1'b0;
    chk("single_mul_a", mul_a, 3);
    chk("single_busy", busy, 1);
    chk("single_not_yet_k0", out_valid, 0);
    tick();
    chk("single_not_yet_k1", out_valid, 0);
    tick();
    chk("single_valid", out_valid, 1);
    chk("single_z", out_z, 15);
    out_ready = 1'b1;
    tick();
    chk("single_empty", out_valid, 0);
    chk("single_idle", busy, 0);

    // Streaming 8 ops with out_ready held
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_a = i; in_b = i + 1;
      chk("stream_in_ready", in_ready, 1);
      tick();
      if (i >= 2) begin
        chk("stream_valid", out_valid, 1);
        chk("stream_z", out_z, (i - 2) * (i - 1));
      end
    end
    in_valid = 1'b0;
    tick();
    chk("stream_z6", out_z, 42);
    tick();
    chk("stream_z7", out_z, 56);
    tick();
    chk("stream_drained", out_valid, 0);

    // Backpressure: only FIFO_DEPTH credits
    out_ready = 1'b0;
    acc = 0;
    for (int j = 0; j < 8; j++) begin
      in_valid = 1'b1; in_a = 10 + j; in_b = 1;
      if (in_ready) acc++;
      tick();
    end
    chk("bp_accepts", acc, 4);
    chk("bp_in_ready_low", in_ready, 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("bp_head0", out_z, 10);
    tick();
    chk("bp_credit_back", in_ready, 1);
    chk("bp_head1", out_z, 11);
    tick();
    chk("bp_head2", out_z, 12);
    tick();
    chk("bp_head3", out_z, 13);
    tick();
    chk("bp_drained", out_valid, 0);

    // Sustained push+pop at count 2 on the 8-deep instance, wrapping pointers
    u2_in_valid = 1'b1; u2_in_b = 1;
    for (int n = 0; n < 4; n++) begin
      u2_in_a = 30 + n;
      tick();
    end
    u2_in_a = 34;
    u2_out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      chk("pp_in_ready", u2_in_ready, 1);
      chk("pp_valid", u2_out_valid, 1);
      chk("pp_head", u2_out_z, 30 + t);
      tick();
      if (5 + t >= 12) u2_in_valid = 1'b0;
      else u2_in_a = 30 + 5 + t;
    end
    chk("pp_tail10", u2_out_z, 40);
    tick();
    chk("pp_tail11", u2_out_z, 41);
    tick();
    chk("pp_exactly_two_left", u2_out_valid, 0);
    chk("pp_idle", u2_busy, 0);

    // Flush with 2 in flight and 2 queued
    out_ready = 1'b0;
    in_valid = 1'b1; in_b = 1;
    for (int n = 0; n < 4; n++) begin
      in_a = 50 + n;
      tick();
    end
    chk("fl_queued", out_valid, 1);
    flush = 1'b1; in_a = 99;
    #1;
    chk("fl_in_ready", in_ready, 0);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_mul_a_hold", mul_a, 53);
    for (int n = 0; n < 3; n++) begin
      tick();
      chk("fl_no_stale", out_valid, 0);
    end
    in_valid = 1'b1; in_a = 4; in_b = 4;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("fl_new_result", out_z, 16);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("fl_new_drained", out_valid, 0);

    // Async reset between edges with 3 ops pending
    in_valid = 1'b1; in_b = 3;
    for (int n = 0; n < 3; n++) begin
      in_a = 2 + n;
      tick();
    end
    in_valid = 1'b0;
    chk("ar_pending", out_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_busy", busy, 0);
    chk("ar_mul_a", mul_a, 0);
    chk("ar_mul_b", mul_b, 0);
    chk("ar_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_a = 7; in_b = 6;
    tick();
    in_valid = 1'b0;
    chk("ar_first_quiet", out_valid, 0);
    tick();
    chk("ar_second_quiet", out_valid, 0);
    tick();
    chk("ar_result_valid", out_valid, 1);
    chk("ar_result_z", out_z, 42);
    out_ready = 1'b1;
    tick();
    chk("ar_only_result", out_valid, 0);
    tick();
    chk("ar_idle", busy, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/mult_issue_ctrl.md
Name: mult_issue_ctrl

Overview:
- Operand issue and result collection stage around the `wallace` multiplier core.
- Accepts operand pairs on a valid/ready interface and drives `input_a`/`input_b` of the core.
- Tracks in-flight products with a MUL_LATENCY-deep valid pipe and captures `output_z` into a small result FIFO with a valid/ready output.
- Credit-based issue: a product always has a FIFO slot when it emerges, so the non-stallable core never loses a result.

Parameters:
- WIDTH, 32: operand and product width; matches the core's 32-bit ports.
- MUL_LATENCY, 2: cycles from operands registered on mul_a/mul_b to a valid mul_z. Legal range 1..8.
- FIFO_DEPTH, 4: result FIFO entries. Power of two, 2..16.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous discard of all in-flight and queued results.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  operand pair accepted when in_valid & in_ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- mul_a  out  WIDTH  registered operand to core input_a.
- mul_b  out  WIDTH  registered operand to core input_b.
- mul_z  in  WIDTH  core output_z (low WIDTH bits of product).
- out_valid  out  1  result FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid & out_ready.
- out_z  out  WIDTH  FIFO head, first-word fall-through.
- busy  out  1  any product in flight or queued.

Behaviour:
- Reset: asynchronous, active-high. All of the following reset to their stated values:
  - mul_a = mul_b = 0
  - valid pipe = 0, inflight = 0
  - FIFO empty: count = 0, rd_ptr = wr_ptr = 0
  - out_valid = 0, out_z = 0 when empty, busy = 0
  - in_ready = 0 while rst is high; in_ready = 1 in the first cycle after release.
- Accept: on an edge with in_valid & in_ready, mul_a/mul_b <= in_a/in_b and pipe[0] <= 1. Otherwise pipe[0] <= 0 and mul_a/mul_b hold.
- Pipe: pipe[i] <= pipe[i-1] each cycle. An accept at edge k pushes mul_z into the FIFO at edge k+MUL_LATENCY, i.e. when pipe[MUL_LATENCY-1] is set.
- Throughput: one op per cycle, no bubbles while credits remain.
- Credits:
  - inflight = popcount(pipe).
  - in_ready = !rst & !flush & (inflight + count < FIFO_DEPTH).
  - Computed from registered state only; no combinational path from out_ready.
  - A pop in the same cycle does not free a credit until the next cycle.
- FIFO:
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - Overflow is impossible by construction.
  - A pop when empty is ignored.
- Output: out_valid = (count != 0). out_z = mem[rd_ptr]. out_z must hold stable while out_valid & !out_ready.
- Flush: on an edge with flush = 1:
  - pipe, inflight and count clear; rd_ptr = wr_ptr.
  - Any accept or push in that cycle is suppressed.
  - mul_a/mul_b hold.
  - Results of ops accepted before the flush never appear.
- busy = (pipe != 0) | (count != 0).
- Reset mid-operation discards all in-flight and queued results; the first post-reset result comes from the first post-reset accept.

Optional Feature:
- MULT_ISSUE_STATS_EN defined: adds two outputs.
  - stat_issued (16 bits): counts accepts.
  - stat_stall (16 bits): counts cycles with in_valid & !in_ready.
  - Both saturate at 0xFFFF, clear on rst, and are unaffected by flush.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single op, defaults: accept (in_a = 3, in_b = 5) at edge k. Core model returns a×b after MUL_LATENCY cycles. Required: push at edge k+2, out_valid = 1 and out_z = 15 from k+2, busy = 0 after pop with out_ready = 1.
- Streaming: 8 back-to-back ops (a = i, b = i+1, i = 0..7) with out_ready = 1 throughout. Required: in_ready stays 1; outputs 0, 2, 6, 12, 20, 30, 42, 56 in order on consecutive cycles.
- Backpressure: out_ready = 0, in_valid = 1 continuously. Required: exactly 4 accepts, then in_ready = 0. Raise out_ready: results drain in order and in_ready returns 1 one cycle after the first pop.
- Simultaneous push/pop: count held at 2 with push and pop every cycle for 10 cycles. Required: count stays 2, no loss or duplication, ordering kept across pointer wrap.
- Flush: 2 ops in flight plus 2 queued, assert flush for one cycle. Required: out_valid = 0 and busy = 0 on the next cycle; in_ready = 0 during the flush cycle; no stale result ever appears.
- Async reset mid-stream: assert rst between edges with 3 ops pending. Required: out_valid, busy, mul_a and mul_b go to 0 immediately without a clock edge. After release, op (7, 6) yields 42 as the only result.
